// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the pipeline exception/stall controller:
// exception type codes, ExcCode values, stall masks and reset defaults.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_RI        = 32'h0000_000a;
  localparam logic [31:0] EXC_OV        = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;
  localparam logic [4:0] CODE_TRAP = 5'd13;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [31:0] DEF_RESET_EBASE   = 32'h0000_0000;
  localparam logic [31:0] DEF_VECTOR_OFFSET = 32'h0000_0020;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic       take;
    logic       eret;
    logic [4:0] code;
  } exc_dec_t;

  // Unrecognised nonzero types decode to nothing so they are silently ignored.
  function automatic exc_dec_t exc_decode(input logic [31:0] etype);
    exc_dec_t d;
    d = '0;
    case (etype)
      EXC_INTERRUPT: begin d.take = 1'b1; d.code = CODE_INT;  end
      EXC_SYSCALL:   begin d.take = 1'b1; d.code = CODE_SYS;  end
      EXC_RI:        begin d.take = 1'b1; d.code = CODE_RI;   end
      EXC_OV:        begin d.take = 1'b1; d.code = CODE_OV;   end
      EXC_TRAP:      begin d.take = 1'b1; d.code = CODE_TRAP; end
      EXC_ERET:      begin d.eret = 1'b1; end
      default:       d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/exc_stall_arb.sv
// Combinational priority encoder: the oldest requesting stage decides how
// much of the pipeline front end is frozen.
module exc_stall_arb
  import exc_ctrl_pkg::*;
(
  input  logic       stallreq_if_i,
  input  logic       stallreq_id_i,
  input  logic       stallreq_ex_i,
  input  logic       stallreq_mem_i,
  output logic [5:0] stall_o
);

  // Priority chain, MEM oldest.
  always_comb begin
    stall_o = STALL_NONE;
    if (stallreq_mem_i == Stop) begin
      stall_o = STALL_MEM;
    end else if (stallreq_ex_i == Stop) begin
      stall_o = STALL_EX;
    end else if (stallreq_id_i == Stop) begin
      stall_o = STALL_ID;
    end else if (stallreq_if_i == Stop) begin
      stall_o = STALL_IF;
    end else begin
      stall_o = STALL_NONE;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Pipeline control: stall arbitration, exception/eret flush and redirect,
// and ownership of EPC, EBASE, Cause.ExcCode, Cause.BD and Status.EXL.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_EBASE   = DEF_RESET_EBASE,
  parameter logic [31:0] VECTOR_OFFSET = DEF_VECTOR_OFFSET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cur_inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic        csr_we,
  input  logic        csr_sel,
  input  logic [31:0] csr_wdata,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] epc_o,
  output logic [31:0] ebase_o,
  output logic [4:0]  exccode_o,
  output logic        bd_o,
  output logic        exl_o
);

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ebase_q, ebase_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        bd_q, bd_d;
  logic        exl_q, exl_d;
  exc_dec_t    dec_s;
  logic [5:0]  arb_stall_s;

  assign dec_s = exc_decode(excepttype_i);

  exc_stall_arb u_stall_arb (
    .stallreq_if_i  (stallreq_if),
    .stallreq_id_i  (stallreq_id),
    .stallreq_ex_i  (stallreq_ex),
    .stallreq_mem_i (stallreq_mem),
    .stall_o        (arb_stall_s)
  );

  // Next-state, CSR update and combinational flush/redirect/stall.
  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    ebase_d   = ebase_q;
    exccode_d = exccode_q;
    bd_d      = bd_q;
    exl_d     = exl_q;
    flush     = 1'b0;
    new_pc    = 32'h0000_0000;
    stall     = STALL_NONE;

    if (csr_we) begin
      if (csr_sel) begin
        ebase_d = csr_wdata;
      end else begin
        epc_d = csr_wdata;
      end
    end else begin
      ebase_d = ebase_q;
    end

    case (state_q)
      ST_RUN: begin
        if (dec_s.take) begin
          flush     = 1'b1;
          new_pc    = ebase_q + VECTOR_OFFSET;
          exccode_d = dec_s.code;
          state_d   = ST_FLUSH;
          // A nested exception keeps the original return point.
          if (!exl_q) begin
            epc_d = in_delayslot_i ? (cur_inst_addr_i - 32'd4) : cur_inst_addr_i;
            bd_d  = in_delayslot_i;
            exl_d = 1'b1;
          end else begin
            epc_d = epc_q;
          end
        end else if (dec_s.eret) begin
          flush   = 1'b1;
          new_pc  = epc_q;
          exl_d   = 1'b0;
          state_d = ST_FLUSH;
        end else begin
          stall = arb_stall_s;
        end
      end
      // Bubbles from killed stages arrive here; ignore them.
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and CSR registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      epc_q     <= 32'h0000_0000;
      ebase_q   <= RESET_EBASE;
      exccode_q <= 5'd0;
      bd_q      <= 1'b0;
      exl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      ebase_q   <= ebase_d;
      exccode_q <= exccode_d;
      bd_q      <= bd_d;
      exl_q     <= exl_d;
    end
  end

  assign epc_o     = epc_q;
  assign ebase_o   = ebase_q;
  assign exccode_o = exccode_q;
  assign bd_o      = bd_q;
  assign exl_o     = exl_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the control unit.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0020;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sif, sid, sex, smem;
  logic [31:0] et, cia;
  logic        ids, csr_we, csr_sel;
  logic [31:0] csr_wdata;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc, epc_o, ebase_o;
  logic [4:0]  exccode_o;
  logic        bd_o, exl_o;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] m_epc = 32'h0, m_ebase = 32'h0;
  logic [4:0]  m_code = 5'd0;
  logic        m_bd = 1'b0, m_exl = 1'b0, m_killed = 1'b0;

  exc_ctrl #(.RESET_EBASE(32'h0000_0000), .VECTOR_OFFSET(VEC)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .excepttype_i(et), .cur_inst_addr_i(cia), .in_delayslot_i(ids),
    .csr_we(csr_we), .csr_sel(csr_sel), .csr_wdata(csr_wdata),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .epc_o(epc_o), .ebase_o(ebase_o), .exccode_o(exccode_o),
    .bd_o(bd_o), .exl_o(exl_o)
  );

  // -1: ignored, 99: eret, otherwise the ExcCode value
  function automatic int code_of(input logic [31:0] t);
    if (t == 32'h1) return 0;
    if (t == 32'h8) return 8;
    if (t == 32'ha) return 10;
    if (t == 32'hc) return 12;
    if (t == 32'hd) return 13;
    if (t == 32'he) return 99;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check combinational outputs and registers, then clock one edge and advance the model.
  task automatic tick();
    int c;
    int n;
    logic        e_fl;
    logic [31:0] e_pc;
    logic [5:0]  e_st;
    #4;
    c = code_of(et);
    if (!rst) begin
      e_fl = 1'b0; e_pc = 32'h0; e_st = 6'h0;
      if (!m_killed && c >= 0) begin
        e_fl = 1'b1;
        e_pc = (c == 99) ? m_epc : (m_ebase + VEC);
      end else if (!m_killed) begin
        // stalled stage count: PC plus every stage up to the oldest requester
        n = smem ? 5 : sex ? 4 : sid ? 3 : sif ? 2 : 0;
        e_st = 6'((1 << n) - 1);
      end
      chk("flush", {31'h0, flush}, {31'h0, e_fl});
      chk("new_pc", new_pc, e_pc);
      chk("stall", {26'h0, stall}, {26'h0, e_st});
    end
    chk("epc", epc_o, m_epc);
    chk("ebase", ebase_o, m_ebase);
    chk("exccode", {27'h0, exccode_o}, {27'h0, m_code});
    chk("bd", {31'h0, bd_o}, {31'h0, m_bd});
    chk("exl", {31'h0, exl_o}, {31'h0, m_exl});
    @(posedge clk);
    if (rst) begin
      m_epc = 32'h0; m_ebase = 32'h0; m_code = 5'd0;
      m_bd = 1'b0; m_exl = 1'b0; m_killed = 1'b0;
    end else begin
      logic entering;
      entering = !m_killed && c >= 0 && c != 99;
      if (csr_we && csr_sel) m_ebase = csr_wdata;
      if (csr_we && !csr_sel && !entering) m_epc = csr_wdata;
      if (m_killed) begin
        m_killed = 1'b0;
      end else if (c == 99) begin
        m_exl = 1'b0;
        m_killed = 1'b1;
      end else if (c >= 0) begin
        m_code = 5'(c);
        if (!m_exl) begin
          m_epc = ids ? cia - 32'd4 : cia;
          m_bd = ids;
          m_exl = 1'b1;
        end
        m_killed = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    sif = 1'b0; sid = 1'b0; sex = 1'b0; smem = 1'b0;
    et = 32'h0; cia = 32'h0; ids = 1'b0;
    csr_we = 1'b0; csr_sel = 1'b0; csr_wdata = 32'h0;
  endtask

  logic [31:0] et_tab [12];

  initial begin
    et_tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h8, 32'ha, 32'hc,
               32'hd, 32'he, 32'h5, 32'hff};
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state with idle inputs
    tick();
    chk("rst_exl", {31'h0, exl_o}, 32'h0);

    // Stall priority: ex beats if
    sex = 1'b1; sif = 1'b1;
    #4;
    chk("stall_ex_if", {26'h0, stall}, {26'h0, 6'b001111});
    #1;
    @(posedge clk); #1;
    idle_inputs();

    // EBASE = 0x1000, then syscall at 0x80
    csr_we = 1'b1; csr_sel = 1'b1; csr_wdata = 32'h1000;
    tick();
    idle_inputs();
    et = 32'h8; cia = 32'h80; smem = 1'b1;
    tick();
    idle_inputs();
    chk("sys_epc", epc_o, 32'h80);
    chk("sys_code", {27'h0, exccode_o}, 32'd8);
    tick();

    // eret, then overflow in a delay slot
    et = 32'he;
    tick();
    idle_inputs();
    tick();
    et = 32'hc; cia = 32'h104; ids = 1'b1;
    tick();
    idle_inputs();
    chk("ov_epc", epc_o, 32'h100);
    chk("ov_bd", {31'h0, bd_o}, 32'h1);
    tick();

    // Trap with EXL already set keeps EPC, then eret returns to 0x100
    et = 32'hd; cia = 32'h200;
    tick();
    idle_inputs();
    chk("trap_epc_hold", epc_o, 32'h100);
    chk("trap_code", {27'h0, exccode_o}, 32'd13);
    tick();
    et = 32'he;
    #4;
    chk("eret_pc", new_pc, 32'h100);
    #1;
    @(posedge clk); #1;
    m_exl = 1'b0; m_killed = 1'b1;
    idle_inputs();
    tick();

    // Held syscall gives a single flush pulse
    et = 32'h8; cia = 32'h300;
    tick();
    tick();
    idle_inputs();
    et = 32'h5; sid = 1'b1;
    tick();
    idle_inputs();

    // eret, then EPC write coincident with syscall entry
    et = 32'he;
    tick();
    idle_inputs();
    tick();
    et = 32'h8; cia = 32'h400;
    csr_we = 1'b1; csr_sel = 1'b0; csr_wdata = 32'hdead_beef;
    tick();
    idle_inputs();
    chk("csr_vs_exc", epc_o, 32'h400);

    // Reset during FLUSH
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ebase", ebase_o, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      sif = $urandom_range(0, 1) == 1;
      sid = $urandom_range(0, 3) == 0;
      sex = $urandom_range(0, 3) == 0;
      smem = $urandom_range(0, 5) == 0;
      et = et_tab[$urandom_range(0, 11)];
      cia = $urandom;
      ids = $urandom_range(0, 1) == 1;
      csr_we = $urandom_range(0, 7) == 0;
      csr_sel = $urandom_range(0, 1) == 1;
      csr_wdata = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Pipeline control unit for the five-stage core. Arbitrates stall requests from the IF, ID, EX and MEM stages into the 6-bit `stall` vector consumed by the PC register and the pipeline registers. Converts the exception type reported by the MEM stage into a one-cycle `flush` plus redirect address `new_pc`. Owns the EPC, EBASE, Cause.ExcCode, Cause.BD and Status.EXL state, so exception entry and `eret` are sequenced in one place.

## Interface
- `RESET_EBASE`, default 32'h0000_0000: EBASE value after reset.
- `VECTOR_OFFSET`, default 32'h0000_0020: offset from EBASE to the general exception handler.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `stallreq_if`, `stallreq_id`, `stallreq_ex`, `stallreq_mem`  in  1 each  stall requests from each stage
- `excepttype_i`  in  32  exception type of the instruction in MEM (0 = none)
- `cur_inst_addr_i`  in  32  PC of the instruction in MEM
- `in_delayslot_i`  in  1  MEM instruction sits in a branch delay slot
- `csr_we`  in  1  register write strobe
- `csr_sel`  in  1  0 = EPC, 1 = EBASE
- `csr_wdata`  in  32  write data
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
- `flush`  out  1  kill all pipeline registers and redirect the PC
- `new_pc`  out  32  redirect target, valid while `flush`=1
- `epc_o`, `ebase_o`  out  32  current EPC and EBASE
- `exccode_o`  out  5  last exception code
- `bd_o`, `exl_o`  out  1  Cause.BD and Status.EXL

## Operation
- FSM has two states: RUN and FLUSH. Reset enters RUN.
- **Recognised exception codes:**
  - 0x1 interrupt → ExcCode 0
  - 0x8 syscall → ExcCode 8
  - 0xa reserved instruction → ExcCode 10
  - 0xc overflow → ExcCode 12
  - 0xd trap → ExcCode 13
  - 0xe eret
  - Any other nonzero value is ignored: no flush, no state change.
- **RUN with a recognised non-eret exception:**
  - `flush`=1 and `new_pc`=EBASE+VECTOR_OFFSET, both combinational in the same cycle.
  - On the next edge: ExcCode is loaded.
  - On the next edge, if EXL=0: EPC = `in_delayslot_i` ? `cur_inst_addr_i`−4 : `cur_inst_addr_i`, BD = `in_delayslot_i`, EXL = 1.
  - If EXL was already 1, EPC and BD hold; the flush and vector still happen.
  - State moves to FLUSH.
- **RUN with eret:** `flush`=1, `new_pc`=EPC (the value before this edge). EXL is cleared on the edge. State moves to FLUSH.
- **FLUSH:** lasts exactly one cycle, then returns to RUN.
  - `flush`=0 and `stall`=0.
  - `excepttype_i` is ignored, because it carries bubbles from the killed stages.
- **Stall arbitration** (RUN, no flush); the oldest requesting stage wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 0
- `flush`=1 forces `stall`=0 regardless of requests.
- **CSR writes:** take effect on the edge and are accepted in either state. If a write to EPC coincides with exception entry, exception entry wins.
- **Arithmetic:** EPC−4 and EBASE+VECTOR_OFFSET are 32-bit modulo operations, with no overflow detection.

## Timing
- **Reset values:**
  - `stall`=0, `flush`=0, `new_pc`=0
  - EPC=0, EBASE=RESET_EBASE
  - ExcCode=0, BD=0, EXL=0
  - state RUN
- Reset overrides every input on the same edge.
- `stall`, `flush` and `new_pc` are combinational from the inputs and the current state. Zero latency is required, so the PC register loads `new_pc` on the edge that ends the flush cycle.
- Register updates (EPC, BD, EXL, ExcCode, state) land on the edge that ends the flush cycle.
- Any stage stall concurrent with an exception is dropped; flush has priority.
- Back-to-back exceptions cannot occur: the cycle after a flush is always FLUSH. An exception presented in that cycle is lost by design, because the pipeline has been killed.
- If reset asserts during FLUSH, the next state is RUN and all registers return to their reset values.

## Structure
- A shared defines package holds:
  - the exception type codes, ExcCode values and stall masks
  - `RESET_EBASE` and `VECTOR_OFFSET` defaults
  - `Stop`/`NoStop`
- Sub-module `exc_stall_arb`: purely combinational priority encoder from stall requests to the stall vector.
- The FSM and CSR registers stay in `exc_ctrl`.

## Test plan
- Reset, then `stallreq_ex`=1 and `stallreq_if`=1 → `stall`=6'b001111, `flush`=0.
- EBASE=0x1000; syscall (0x8) at 0x80, not in a delay slot → same cycle `flush`=1, `new_pc`=0x1020, `stall`=0. Next cycle: EPC=0x80, ExcCode=8, EXL=1, `flush`=0.
- Overflow (0xc) at 0x104 with `in_delayslot_i`=1 → EPC=0x100, BD=1.
- With EXL=1, trap at 0x200 → `new_pc`=vector, EPC unchanged, ExcCode=13. Then eret → `new_pc`=old EPC, EXL=0.
- `excepttype_i`=0x8 held for two cycles → single flush pulse; second cycle ignored. Code 0x5 → no flush.
- CSR write to EPC coincident with an exception → EPC takes the exception value. Reset during FLUSH → all outputs return to reset values next cycle.
